// File: rtl/wb_arbiter.sv
// Writeback arbiter and load scoreboard feeding the single register-file write port.
// Optional macro WB_BYPASS_EN adds rs1_fwd/rs2_fwd and drops the writeback term from rsX_busy.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        issue_busy,
  output logic        we,
  output logic [4:0]  rd,
  output logic [31:0] wd
`ifdef WB_BYPASS_EN
  ,
  output logic        rs1_fwd,
  output logic        rs2_fwd
`endif
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic [3:0]  starve_q, starve_d;
  logic [31:0] busy_q, busy_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wd_q, wd_d;

  logic forceLd, aluAcc, ldAcc, wbHit1, wbHit2;

  // A starved load overrides the ALU's default priority; the two accepts are mutually exclusive.
  always_comb begin
    forceLd   = (starve_q >= Limit);
    alu_ready = !forceLd;
    ld_ready  = forceLd || !alu_valid;
    aluAcc    = alu_valid && alu_ready;
    ldAcc     = ld_valid && ld_ready;
  end

  always_comb begin
    starve_d = (ld_valid && !ldAcc) ? starve_q + 4'd1 : 4'd0;
    we_d     = 1'b0;
    rd_d     = rd_q;
    wd_d     = wd_q;
    if (aluAcc) begin
      we_d = (alu_rd != 5'd0);
      rd_d = alu_rd;
      wd_d = alu_data;
    end else if (ldAcc) begin
      we_d = (ld_rd != 5'd0);
      rd_d = ld_rd;
      wd_d = ld_data;
    end
    // Set is applied after clear so a same-edge reissue keeps the register busy.
    busy_d = busy_q;
    if (ldAcc) busy_d[ld_rd] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 4'd0;
      busy_q   <= 32'd0;
      we_q     <= 1'b0;
      rd_q     <= 5'd0;
      wd_q     <= 32'd0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      wd_q     <= wd_d;
    end
  end

  always_comb begin
    we         = we_q;
    rd         = rd_q;
    wd         = wd_q;
    issue_busy = busy_q[issue_rd];
    wbHit1     = we_q && (rd_q == rs1) && (rs1 != 5'd0);
    wbHit2     = we_q && (rd_q == rs2) && (rs2 != 5'd0);
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    rs1_busy = busy_q[rs1];
    rs2_busy = busy_q[rs2];
    rs1_fwd  = wbHit1;
    rs2_fwd  = wbHit2;
  end
`else
  // The async-read register file does not yet hold the value being written this cycle.
  always_comb begin
    rs1_busy = busy_q[rs1] | wbHit1;
    rs2_busy = busy_q[rs2] | wbHit2;
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed scenarios followed by randomized traffic
// checked against a behavioural model of arbitration, starvation and the load scoreboard.
module tb_wb_arbiter;

  localparam int STARVE_LIMIT = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } wr_t;

  logic        clk, rst;
  logic        alu_valid, alu_ready, ld_valid, ld_ready;
  logic [4:0]  alu_rd, ld_rd, issue_rd, rs1, rs2, rd;
  logic [31:0] alu_data, ld_data, wd;
  logic        issue_valid, rs1_busy, rs2_busy, issue_busy, we;
`ifdef WB_BYPASS_EN
  logic        rs1_fwd, rs2_fwd;
`endif

  wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .issue_busy(issue_busy),
    .we(we), .rd(rd), .wd(wd)
`ifdef WB_BYPASS_EN
    , .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  wr_t expQ[$];

  // Model state: set of registers awaiting load data, cycles the head load has waited,
  // and the write the register file is receiving this cycle.
  bit         mBusy[32];
  int         mWait;
  bit         mWe;
  logic [4:0] mRd;
  bit         aluPend, ldPend;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mBusy[i] = 1'b0;
    mWait   = 0;
    mWe     = 1'b0;
    mRd     = 5'd0;
    aluPend = 1'b0;
    ldPend  = 1'b0;
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                               input logic iv, input logic [4:0] ird,
                               input logic [4:0] r1, input logic [4:0] r2);
    bit forced, expAluRdy, expLdRdy, hit1, hit2, aluAcc, ldAcc;
    @(negedge clk);
    alu_valid = av;  alu_rd = ard; alu_data = adat;
    ld_valid  = lv;  ld_rd  = lrd; ld_data  = ldat;
    issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
    #1;
    forced    = (mWait >= STARVE_LIMIT);
    expAluRdy = !forced;
    expLdRdy  = forced || !av;
    hit1      = mWe && (mRd == r1) && (r1 != 5'd0);
    hit2      = mWe && (mRd == r2) && (r2 != 5'd0);
    checkOutput("we", we, mWe);
    checkOutput("alu_ready", alu_ready, expAluRdy);
    checkOutput("ld_ready", ld_ready, expLdRdy);
    checkOutput("issue_busy", issue_busy, mBusy[ird]);
`ifdef WB_BYPASS_EN
    checkOutput("rs1_busy", rs1_busy, mBusy[r1]);
    checkOutput("rs2_busy", rs2_busy, mBusy[r2]);
    checkOutput("rs1_fwd", rs1_fwd, hit1);
    checkOutput("rs2_fwd", rs2_fwd, hit2);
`else
    checkOutput("rs1_busy", rs1_busy, mBusy[r1] | hit1);
    checkOutput("rs2_busy", rs2_busy, mBusy[r2] | hit2);
`endif
    aluAcc = av && expAluRdy;
    ldAcc  = lv && expLdRdy;
    mWe = 1'b0;
    if (aluAcc) begin
      mWe = (ard != 5'd0);
      mRd = ard;
      if (mWe) expQ.push_back('{ard, adat});
    end else if (ldAcc) begin
      mWe = (lrd != 5'd0);
      mRd = lrd;
      if (mWe) expQ.push_back('{lrd, ldat});
    end
    if (ldAcc) mBusy[lrd] = 1'b0;
    if (iv && ird != 5'd0) mBusy[ird] = 1'b1;
    mWait   = (lv && !ldAcc) ? mWait + 1 : 0;
    aluPend = av && !aluAcc;
    ldPend  = lv && !ldAcc;
  endtask

  task automatic idle(input logic [4:0] ird, input logic [4:0] r1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, ird, r1, 0);
  endtask

  // Monitor: every write the DUT presents must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && we) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL wb_unexpected: got rd=%0d wd=0x%08h expected no write", rd, wd);
        end else begin
          e = expQ.pop_front();
          checkOutput("wb_rd", {27'd0, rd}, {27'd0, e.rd});
          checkOutput("wb_wd", wd, e.wd);
        end
      end
    end
  end

  initial begin
    logic        av, lv, iv;
    logic [4:0]  ard, lrd, ird;
    logic [31:0] adat, ldat;

    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    modelReset();
    #2;
    checkOutput("rst_we", we, 0);
    checkOutput("rst_rd", {27'd0, rd}, 0);
    checkOutput("rst_wd", wd, 0);
    checkOutput("rst_alu_ready", alu_ready, 1);
    checkOutput("rst_ld_ready", ld_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // ALU write, then write to x0.
    applyStimulus(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 32'h5555_AAAA, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("alu_we", we, 1);
    checkOutput("alu_rd", {27'd0, rd}, 5);
    checkOutput("alu_wd", wd, 32'hDEAD_BEEF);
    idle(0, 0);
    checkOutput("x0_we", we, 0);

    // Load hazard on x7.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(7, 7);
    checkOutput("hz_rs1_busy_n1", rs1_busy, 1);
    checkOutput("hz_issue_busy", issue_busy, 1);
    idle(7, 7);
    applyStimulus(0, 0, 0, 1, 7, 32'h1234, 0, 7, 7, 0);
    idle(7, 7);
    checkOutput("hz_we", we, 1);
    checkOutput("hz_rd", {27'd0, rd}, 7);
    checkOutput("hz_wd", wd, 32'h1234);
`ifdef WB_BYPASS_EN
    checkOutput("hz_rs1_busy_n4", rs1_busy, 0);
    checkOutput("hz_rs1_fwd_n4", rs1_fwd, 1);
`else
    checkOutput("hz_rs1_busy_n4", rs1_busy, 1);
`endif
    idle(7, 7);
    checkOutput("hz_rs1_busy_n5", rs1_busy, 0);

    // Starvation: both sources valid; load forced through on its 5th waiting cycle.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 5'(10 + i), 32'h1000_0000 + i, 1, 20, 32'hABCD, 0, 0, 0, 0);
      if (i < 5) checkOutput("st_ld_ready_wait", ld_ready, 0);
    end
    checkOutput("st_ld_ready_5", ld_ready, 1);
    checkOutput("st_alu_ready_5", alu_ready, 0);
    applyStimulus(1, 15, 32'h1000_0005, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("st_ld_written", {27'd0, rd}, 20);
    checkOutput("st_alu_ready_6", alu_ready, 1);
    idle(0, 0);
    checkOutput("st_alu_written", {27'd0, rd}, 15);
    checkOutput("st_alu_wd", wd, 32'h1000_0005);

    // Set/clear collision on x9.
    applyStimulus(0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 0);
    idle(9, 0);
    checkOutput("col_busy9", issue_busy, 1);
    checkOutput("col_rd", {27'd0, rd}, 9);
    checkOutput("col_we", we, 1);

    // Unmarked load to x3.
    applyStimulus(0, 0, 0, 1, 3, 32'h33, 0, 3, 0, 0);
    idle(3, 0);
    checkOutput("um_we", we, 1);
    checkOutput("um_rd", {27'd0, rd}, 3);
    checkOutput("um_busy3", issue_busy, 0);

    // Randomized traffic; pending handshakes hold their payload until accepted.
    av = 0; lv = 0; ard = 0; lrd = 0; adat = 0; ldat = 0;
    for (int n = 0; n < 400; n++) begin
      if (!aluPend) begin
        av   = ($urandom_range(0, 99) < 60);
        ard  = 5'($urandom_range(0, 7));
        adat = $urandom;
      end
      if (!ldPend) begin
        lv   = ($urandom_range(0, 99) < 50);
        lrd  = 5'($urandom_range(0, 7));
        ldat = $urandom;
      end
      ird = 5'($urandom_range(0, 7));
      iv  = ($urandom_range(0, 3) == 0) && !mBusy[ird];
      applyStimulus(av, ard, adat, lv, lrd, ldat, iv, ird,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(0, 0);
    idle(0, 0);

    // Asynchronous reset mid-cycle with busy = 0x0000_0F00 and a write in flight.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 8, 8, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 8, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 10, 8, 0);
    applyStimulus(1, 12, 32'hCAFE_F00D, 0, 0, 0, 1, 11, 8, 0);
    @(posedge clk);
    #3;
    alu_valid = 0;
    issue_valid = 0;
    #1;
    checkOutput("pre_rst_we", we, 1);
    checkOutput("pre_rst_busy11", issue_busy, 1);
    checkOutput("pre_rst_rs1_busy8", rs1_busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_we", we, 0);
    checkOutput("mid_rst_busy11", issue_busy, 0);
    checkOutput("mid_rst_rs1_busy8", rs1_busy, 0);
    checkOutput("mid_rst_alu_ready", alu_ready, 1);
    checkOutput("mid_rst_ld_ready_idle", ld_ready, 1);
    alu_valid = 1;
    #1;
    checkOutput("mid_rst_ld_ready_alu", ld_ready, 0);
    alu_valid = 0;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    idle(11, 8);
    idle(0, 0);

    checkOutput("queue_empty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and load scoreboard sitting between the execute/memory stages and the 32-entry register file write port. Merges ALU results and load-unit results onto the single write port via valid/ready handshakes. Tracks registers with outstanding loads so decode can stall on RAW/WAW hazards. x0 is never written and never marked busy.

## Interface
- `STARVE_LIMIT`, 4: consecutive cycles a pending load may lose arbitration before it is forced through (1..15).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `alu_valid` in 1: ALU result present.
- `alu_ready` out 1: ALU result accepted this cycle.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `ld_valid` in 1: load data present.
- `ld_ready` out 1: load data accepted this cycle.
- `ld_rd` in 5: load destination register.
- `ld_data` in 32: load data.
- `issue_valid` in 1: decode issues a load this cycle.
- `issue_rd` in 5: destination register of the issued load.
- `rs1`, `rs2` in 5 each: decode source addresses to check.
- `rs1_busy`, `rs2_busy` out 1 each: source is unavailable and decode must stall.
- `issue_busy` out 1: `issue_rd` already has a pending load (WAW). Decode must not issue.
- `we` out 1: register file write enable.
- `rd` out 5: register file write address.
- `wd` out 32: register file write data.
- `rs1_fwd`, `rs2_fwd` out 1 each: present only with `WB_BYPASS_EN`. Source may be taken from `wd`.

## Operation
- Arbitration is combinational in cycle N.
  - The ALU wins by default: `alu_ready`=1, `ld_ready`=!`alu_valid`.
  - Starvation counter `starve` (4 bits) increments each cycle `ld_valid` && !`ld_ready`. It resets to 0 whenever a load is accepted or `ld_valid`=0.
  - When `starve` >= `STARVE_LIMIT`: `ld_ready`=1 and `alu_ready`=0. The ALU must hold its inputs stable.
- The accepted winner is captured into `we`/`rd`/`wd` at the next edge. If nothing is accepted, `we` is 0 and `rd`/`wd` hold their values.
- Any accepted result with destination 0 produces `we`=0. The handshake still completes.
- Scoreboard `busy[31:0]`, where bit 0 is constant 0:
  - Set `busy[issue_rd]` on an edge with `issue_valid` && `issue_rd`!=0.
  - Clear `busy[ld_rd]` on an edge where the load is accepted.
  - If set and clear hit the same register on the same edge, set wins.
- Hazard outputs, all combinational:
  - `issue_busy` = `busy[issue_rd]`.
  - Without bypass: `rsX_busy` = `busy[rsX]` | (`we` && `rd`==`rsX` && `rsX`!=0). This covers the write not yet visible through the async-read register file.
- Load accepted while its scoreboard bit is clear is legal. The data is written and the bit stays clear.
- Reset mid-operation clears `busy`, `starve`, `we`, `rd`, `wd` immediately. Any in-flight handshake is dropped.

## Timing
- Reset values: `we`=0, `rd`=0, `wd`=0, `busy`=0, `starve`=0.
  - Combinational outputs follow from these: `rsX_busy`=0, `issue_busy`=0, `alu_ready`=1, `ld_ready`=!`alu_valid`.
- Latency: result accepted in cycle N produces `we`/`rd`/`wd` in cycle N+1. The register file commits at the end of N+1.
- `busy` for a load issued in N is visible in N+1.
- A load accepted in N drops its busy bit in N+1. In N+1 the `we`/`rd` match term keeps the source stalled (no bypass). From N+2 the register file holds the value.
- Throughput: one write per cycle. With both sources valid every cycle and `STARVE_LIMIT`=4, the load is accepted in the 5th cycle of waiting.

## Configuration
- Macro: `WB_BYPASS_EN`.
- Defined:
  - `rsX_fwd` = `we` && `rd`==`rsX` && `rsX`!=0.
  - `rsX_busy` = `busy[rsX]` only. Decode muxes `wd` in place of the register file value when `rsX_fwd` is set.
- Undefined:
  - `rsX_fwd` ports do not exist.
  - `rsX_busy` includes the writeback match term, costing one stall cycle per back-to-back dependency.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle with `busy`=0x0000_0F00 and `we`=1. Expect `busy`=0 and `we`=0 immediately. `alu_ready`=1, and `ld_ready`=!`alu_valid`.
- **ALU write:** `alu_valid`, `alu_rd`=5, `alu_data`=0xDEAD_BEEF in cycle N. Expect `we`=1, `rd`=5, `wd`=0xDEAD_BEEF in N+1. With `alu_rd`=0, expect `we`=0 in N+1.
- **Load hazard:** issue load to x7 in N.
  - Expect `rs1_busy`=1 for `rs1`=7 from N+1, and `issue_busy`=1 for `issue_rd`=7.
  - `ld_valid`, `ld_rd`=7, `ld_data`=0x1234 in N+3 produces `we`/`rd`=7/`wd`=0x1234 in N+4.
  - `rs1_busy` is 1 in N+4 and 0 in N+5 without the macro. It is 0 in N+4 with `rs1_fwd`=1 when the macro is defined.
- **Starvation:** `alu_valid` and `ld_valid` held high, `STARVE_LIMIT`=4. Expect `ld_ready`=0 for 4 cycles. In the 5th cycle `ld_ready`=1 and `alu_ready`=0. The ALU result is written the following cycle.
- **Set/clear collision:** load to x9 accepted on the same edge as `issue_valid`/`issue_rd`=9. Expect `busy[9]`=1 afterwards and `we`/`rd`=9 written.
- **Unmarked load:** load to x3 accepted with `busy[3]`=0. Expect the write to occur and `busy` unchanged.
